// File: rtl/divu_hilo_unit_pkg.sv
// Shared encodings for the DIVU/MFHI/MFLO unit: FSM states, HI/LO read selects,
// decoder funct codes and the default datapath width.
package divu_pkg;

  localparam int DIVU_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] SEL_HI = 2'b10;
  localparam logic [1:0] SEL_LO = 2'b11;

  localparam logic [5:0] F_DIVU = 6'd27;
  localparam logic [5:0] F_MFHI = 6'd16;
  localparam logic [5:0] F_MFLO = 6'd18;

  // Decoder helpers: funct field to HI/LO read select, and DIVU issue detect.
  function automatic logic [1:0] funct_to_sel(input logic [5:0] funct);
    case (funct)
      F_MFHI:  return SEL_HI;
      F_MFLO:  return SEL_LO;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic is_divu(input logic [5:0] funct);
    return funct == F_DIVU;
  endfunction

endpackage

// File: rtl/divu_hilo_unit_if.sv
// Command/result bundle between the EX-stage control and the divider.
// With DIVU_ZERO_FLAG_EN defined the bundle also carries div_zero.
interface divu_hilo_unit_if #(parameter int WIDTH = 32);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [1:0]       sel;
  logic [WIDTH-1:0] rd_data;
  logic             busy;
  logic             done;
  logic             stall;
`ifdef DIVU_ZERO_FLAG_EN
  logic             div_zero;
`endif

  modport master (
    output start, dividend, divisor, sel,
`ifdef DIVU_ZERO_FLAG_EN
    input  div_zero,
`endif
    input  rd_data, busy, done, stall
  );

  modport slave (
    input  start, dividend, divisor, sel,
`ifdef DIVU_ZERO_FLAG_EN
    output div_zero,
`endif
    output rd_data, busy, done, stall
  );
endinterface

// File: rtl/divu_hilo_unit_step.sv
// One restoring-division step: shift {rem,quo} left, subtract divisor if it fits.
module divu_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_n,
  output logic [WIDTH-1:0] quo_n
);

  // The shifted remainder needs one extra bit: it can reach 2*divisor-1.
  logic [WIDTH:0] rem_sh;
  logic           fits;

  assign rem_sh = {rem, quo[WIDTH-1]};
  assign fits   = rem_sh >= {1'b0, divisor};
  assign rem_n  = fits ? WIDTH'(rem_sh - {1'b0, divisor}) : rem_sh[WIDTH-1:0];
  assign quo_n  = {quo[WIDTH-2:0], fits};

endmodule

// File: rtl/divu_hilo_unit.sv
// Multi-cycle unsigned divider owning the HI/LO registers; one step per cycle.
// Optional div_zero output enabled by defining DIVU_ZERO_FLAG_EN.
module divu_hilo_unit
  import divu_pkg::*;
#(
  parameter int WIDTH = DIVU_WIDTH
) (
  input  logic            clk,
  input  logic            rst,
  divu_hilo_unit_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] rem, quo, dsr;
  logic [WIDTH-1:0] rem_n, quo_n;
  logic [WIDTH-1:0] hi, lo;
  logic             busy_q, done_q;
`ifdef DIVU_ZERO_FLAG_EN
  logic             zero_q;
`endif

  divu_step #(.WIDTH(WIDTH)) u_step (
    .rem     (rem),
    .quo     (quo),
    .divisor (dsr),
    .rem_n   (rem_n),
    .quo_n   (quo_n)
  );

  // NOTE: every register below is updated with <= so all reads in this block
  // see the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      count  <= '0;
      rem    <= '0;
      quo    <= '0;
      dsr    <= '0;
      hi     <= '0;
      lo     <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
`ifdef DIVU_ZERO_FLAG_EN
      zero_q <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            quo    <= bus.dividend;
            dsr    <= bus.divisor;
            rem    <= '0;
            count  <= '0;
            busy_q <= 1'b1;
            state  <= RUN;
`ifdef DIVU_ZERO_FLAG_EN
            zero_q <= (bus.divisor == '0);
`endif
          end
        end
        RUN: begin
          rem   <= rem_n;
          quo   <= quo_n;
          count <= count + CW'(1);
          // The final step's result goes straight into HI/LO on DONE entry.
          if (count == CW'(WIDTH - 1)) begin
            hi     <= rem_n;
            lo     <= quo_n;
            done_q <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  // NOTE: rd_data gets a default before the case so no latch is inferred.
  always_comb begin
    bus.rd_data = '0;
    case (bus.sel)
      SEL_HI:  bus.rd_data = hi;
      SEL_LO:  bus.rd_data = lo;
      default: bus.rd_data = '0;
    endcase
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.stall = busy_q & bus.sel[1];
`ifdef DIVU_ZERO_FLAG_EN
  assign bus.div_zero = zero_q;
`endif

endmodule

// File: tb/tb_divu_hilo_unit.sv
// Directed-vector bench for divu_hilo_unit: latency, results, interlock, reset abort.
module tb_divu_hilo_unit;
  import divu_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  divu_hilo_unit_if #(.WIDTH(W)) bus ();

  divu_hilo_unit #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    bus.dividend = a;
    bus.divisor  = b;
    bus.start    = 1'b1;
    tick();
    bus.start    = 1'b0;
  endtask

  task automatic read_hilo(input string tag, input logic [W-1:0] exp_lo, input logic [W-1:0] exp_hi);
    bus.sel = SEL_LO;
    #1 check({tag, "_lo"}, bus.rd_data, exp_lo);
    bus.sel = SEL_HI;
    #1 check({tag, "_hi"}, bus.rd_data, exp_hi);
    check({tag, "_stall_idle"}, {31'd0, bus.stall}, 0);
    bus.sel = 2'b00;
    #1;
  endtask

  // Full division with latency checks: busy for 33 cycles, single done at cycle 32.
  task automatic run_div(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] exp_lo, input logic [W-1:0] exp_hi);
    int n       = 0;
    int done_at = -1;
    int dones   = 0;
    issue(a, b);
    check({tag, "_busy0"}, {31'd0, bus.busy}, 1);
    while (bus.busy && n < 60) begin
      tick();
      n++;
      if (bus.done) begin
        done_at = n;
        dones++;
      end
    end
    check({tag, "_busy_len"}, n, 33);
    check({tag, "_done_at"}, done_at, 32);
    check({tag, "_done_cnt"}, dones, 1);
    read_hilo(tag, exp_lo, exp_hi);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    bus.sel      = 2'b00;

    // 1. reset state
    tick();
    tick();
    rst = 1'b0;
    check("rst_busy", {31'd0, bus.busy}, 0);
    check("rst_done", {31'd0, bus.done}, 0);
    check("rst_sel0", bus.rd_data, 0);
    bus.sel = SEL_HI;
    #1 check("rst_hi", bus.rd_data, 0);
    check("rst_stall", {31'd0, bus.stall}, 0);
    bus.sel = SEL_LO;
    #1 check("rst_lo", bus.rd_data, 0);
    bus.sel = 2'b00;
`ifdef DIVU_ZERO_FLAG_EN
    check("rst_dz", {31'd0, bus.div_zero}, 0);
`endif

    // 2-4. basic results, full-scale, quotient zero, divide by zero
    run_div("d100_7", 32'd100, 32'd7, 32'd14, 32'd2);
    run_div("dmax_1", 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0);
    run_div("d5_10", 32'd5, 32'd10, 32'd0, 32'd5);
    run_div("d1234_0", 32'd1234, 32'd0, 32'hFFFF_FFFF, 32'd1234);
`ifdef DIVU_ZERO_FLAG_EN
    check("dz_held", {31'd0, bus.div_zero}, 1);
`endif

    // 5. MFLO interlock with an ignored mid-run start
    begin
      int n        = 0;
      int stall_lo = 0;
      issue(32'd1000, 32'd3);
`ifdef DIVU_ZERO_FLAG_EN
      check("dz_clear", {31'd0, bus.div_zero}, 0);
`endif
      bus.sel = SEL_LO;
      #1 check("il_stall0", {31'd0, bus.stall}, 1);
      while (bus.busy && n < 60) begin
        tick();
        n++;
        bus.start = 1'b0;
        if (n <= 32 && !bus.stall) stall_lo++;
        if (n == 32) check("il_done_lo", bus.rd_data, 32'd333);
        if (n == 5) begin
          bus.dividend = 32'd9;
          bus.divisor  = 32'd9;
          bus.start    = 1'b1;
        end
      end
      check("il_len", n, 33);
      check("il_stall_gaps", stall_lo, 0);
      check("il_stall_rel", {31'd0, bus.stall}, 0);
      check("il_lo_rel", bus.rd_data, 32'd333);
      bus.sel = SEL_HI;
      #1 check("il_hi", bus.rd_data, 32'd1);
      bus.sel = 2'b00;
      tick();
      check("il_no_restart", {31'd0, bus.busy}, 0);
    end

    // 6. reset mid-division, then a fresh run
    begin
      int dones = 0;
      issue(32'd50, 32'd3);
      for (int i = 1; i < 10; i++) begin
        tick();
        if (bus.done) dones++;
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("ab_done_seen", dones, 0);
      check("ab_busy", {31'd0, bus.busy}, 0);
      check("ab_done", {31'd0, bus.done}, 0);
      read_hilo("ab", 32'd0, 32'd0);
      run_div("d50_3", 32'd50, 32'd3, 32'd16, 32'd2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
